// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
// Holds the FSM state encoding, the counter-width helper and the simulation debounce default.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    // Short debounce window used by simulation; hardware builds use the top-level default.
    localparam int SIM_DEBOUNCE_CYCLES = 8;

    // Bits needed to hold counts 0 .. n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for one asynchronous input pin.
// RESET_VALUE should be the pin's inactive level so reset never produces a false edge downstream.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronizes key, filters bounce, emits a level plus press/release strobes.
// Optional auto-repeat on press is enabled by defining KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic pressed,
    output logic press,
    // 'release' is a reserved word, so the release strobe carries a suffix.
    output logic release_pulse
);

    localparam int               CNT_W          = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             KEY_IDLE_LEVEL = (KEY_ACTIVE_LOW != 0);

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_hit;
`endif

    logic key_sync;
    logic k;

    sync_2ff #(
        .RESET_VALUE (KEY_IDLE_LEVEL)
    ) u_key_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (key),
        .q     (key_sync)
    );

    assign k = (KEY_ACTIVE_LOW != 0) ? ~key_sync : key_sync;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_hit     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (k) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!k) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    press_d   = 1'b1;
                    pressed_d = 1'b1;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!k) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                else begin
                    // First strobe waits the long delay, later ones the shorter period.
                    rep_hit = rep_first_q ? (rep_cnt_q == REP_DELAY_LAST)
                                          : (rep_cnt_q == REP_PERIOD_LAST);
                    if (rep_hit) begin
                        press_d     = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                if (k) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    pressed_d = 1'b0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign pressed       = pressed_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: DEBOUNCE_CYCLES=8, active-low key.
// Inputs change and outputs are sampled 1 time unit after the falling clock edge.
module tb_key_debouncer;
    import key_debouncer_pkg::*;

    localparam int DB = SIM_DEBOUNCE_CYCLES;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key       = 1'b1;
    logic pressed;
    logic press;
    logic release_pulse;

    int ecnt      = 0;
    int n_release = 0;
    int n_both    = 0;
    int press_edges[$];
    int n_checks  = 0;
    int n_fail    = 0;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DB),
        .KEY_ACTIVE_LOW  (1)
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
`endif
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .key           (key),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Number of rising edges seen so far.
    always @(posedge sys_clk) ecnt <= ecnt + 1;

    always @(negedge sys_clk) begin
        if (press) press_edges.push_back(ecnt);
        if (release_pulse) n_release++;
        if (press && release_pulse) n_both++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int base;
        int idx;
        int rel0;
        int exp_off[$];

        // Reset with the key released.
        step(3);
        check("rst_pressed", pressed, 0);
        check("rst_press", press, 0);
        check("rst_release", release_pulse, 0);
        sys_rst_n = 1'b1;
        step(2);

        // 1: clean press, strobe at edge 10.
        idx  = press_edges.size();
        key  = 1'b0;
        base = ecnt;
        step(10);
        check("s1_press_e9", press, 0);
        check("s1_pressed_e9", pressed, 0);
        step(1);
        check("s1_press_e10", press, 1);
        check("s1_pressed_e10", pressed, 1);
        step(1);
        check("s1_press_e11", press, 0);
        check("s1_pressed_e11", pressed, 1);
        check("s1_n_press", press_edges.size() - idx, 1);
        if (press_edges.size() > idx) check("s1_press_edge", press_edges[idx] - base - 1, 10);

        // 3a: 5-cycle release glitch while held.
        rel0 = n_release;
        key  = 1'b1;
        step(5);
        key  = 1'b0;
        step(20);
        check("s3_held_release", n_release - rel0, 0);
        check("s3_held_pressed", pressed, 1);
`ifndef KEY_DEBOUNCER_AUTOREPEAT_EN
        check("s3_held_press", press_edges.size() - idx, 1);
`endif

        // 4: clean release, strobe at edge 10.
        rel0 = n_release;
        key  = 1'b1;
        step(10);
        check("s4_release_e9", release_pulse, 0);
        check("s4_pressed_e9", pressed, 1);
        step(1);
        check("s4_release_e10", release_pulse, 1);
        check("s4_pressed_e10", pressed, 0);
        check("s4_press_e10", press, 0);
        step(1);
        check("s4_release_e11", release_pulse, 0);
        check("s4_n_release", n_release - rel0, 1);

        // 3b: 5-cycle press glitch while idle.
        idx = press_edges.size();
        key = 1'b0;
        step(5);
        key = 1'b1;
        step(20);
        check("s3_idle_press", press_edges.size() - idx, 0);
        check("s3_idle_pressed", pressed, 0);

        // 2: bounce every 3 cycles for 24 cycles, then settle pressed.
        idx  = press_edges.size();
        rel0 = n_release;
        for (int i = 0; i < 8; i++) begin
            key = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(3);
        end
        check("s2_bounce_quiet", press_edges.size() - idx, 0);
        key  = 1'b0;
        base = ecnt;
        step(10);
        check("s2_press_e9", press, 0);
        step(1);
        check("s2_press_e10", press, 1);
        step(1);
        check("s2_n_press", press_edges.size() - idx, 1);
        check("s2_n_release", n_release - rel0, 0);
        key = 1'b1;
        step(12);
        check("s2_released", pressed, 0);

        // 5: reset during PRESS_WAIT (count 5) with the key still held.
        key = 1'b0;
        step(8);
        sys_rst_n = 1'b0;
        step(1);
        check("s5_rst_press_a", press, 0);
        check("s5_rst_pressed_a", pressed, 0);
        step(2);
        check("s5_rst_press_b", press, 0);
        check("s5_rst_pressed_b", pressed, 0);
        idx       = press_edges.size();
        sys_rst_n = 1'b1;
        base      = ecnt;
        step(10);
        check("s5_press_e9", press, 0);
        step(1);
        check("s5_press_e10", press, 1);
        check("s5_pressed_e10", pressed, 1);
        check("s5_n_press", press_edges.size() - idx, 1);
        key = 1'b1;
        step(12);
        check("s5_released", pressed, 0);

        // 6: hold 40 cycles past the accepted press.
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        exp_off = '{10, 30, 35, 40, 45, 50};
`else
        exp_off = '{10};
`endif
        idx  = press_edges.size();
        key  = 1'b0;
        base = ecnt;
        step(51);
        key = 1'b1;
        step(15);
        check("s6_n_press", press_edges.size() - idx, exp_off.size());
        for (int j = 0; j < exp_off.size(); j++) begin
            if (idx + j < press_edges.size())
                check($sformatf("s6_press_%0d", j), press_edges[idx + j] - base - 1, exp_off[j]);
        end
        check("s6_released", pressed, 0);
        check("no_coincident_strobes", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
